sound_dac_sd: RTL and testbench

Multi-channel, parametrised first-order sigma-delta audio DAC with a buffered sample interface. Each channel accepts unsigned samples through a valid/ready port, double-buffers them behind an internal sample-rate divider, and applies a per-channel attenuation shift. It also mixes in the 1-bit PC speaker at half scale and emits one pulse-density bit per channel per clock. It sits between the sound/DMA logic and the board's RC-filtered audio pins, and replaces the fixed 8-bit single-channel DAC.

---
 rtl/sound_dac_sd.sv | 83 ++++++++
 tb/tb_sound_dac_sd.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/sound_dac_sd.sv
// sound_dac_sd: multi-channel first-order sigma-delta audio DAC with double-buffered sample input and PC speaker mix
module sound_dac_sd #(
    parameter int WIDTH = 8,
    parameter int CHANNELS = 2,
    parameter int RATE_DIV = 512,
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [CW-1:0]           s_chan,
    input  logic [WIDTH-1:0]        s_data,
    input  logic [3*CHANNELS-1:0]   atten,
    input  logic                    speaker,
    output logic                    tick,
    output logic [CHANNELS-1:0]     underrun,
    output logic [CHANNELS-1:0]     audio_out
);
    localparam int NW = $clog2(RATE_DIV);
    localparam logic [WIDTH:0] HALF = (WIDTH+1)'(1) << (WIDTH-1);
    localparam logic [WIDTH-1:0] MID = WIDTH'(1) << (WIDTH-1);

    logic [NW-1:0] cnt_q, cnt_d;
    logic tick_i, tick_q;
    logic [CHANNELS-1:0] pf_q, pf_d, und_q, und_d, aud_q, aud_d, sel, wr;
    logic [WIDTH-1:0] pend_q [CHANNELS];
    logic [WIDTH-1:0] pend_d [CHANNELS];
    logic [WIDTH-1:0] act_q [CHANNELS];
    logic [WIDTH-1:0] act_d [CHANNELS];
    logic [WIDTH:0] acc_q [CHANNELS];
    logic [WIDTH:0] acc_d [CHANNELS];
    logic [WIDTH:0] v [CHANNELS];
    logic [WIDTH+1:0] sum [CHANNELS];
    logic [2:0] att [CHANNELS];

    always_comb begin
        tick_i = cnt_q == NW'(RATE_DIV - 1);
        cnt_d = tick_i ? '0 : cnt_q + 1'b1;
        for (int c = 0; c < CHANNELS; c++) sel[c] = s_chan == CW'(c);
        wr = {CHANNELS{s_valid}} & sel & ~pf_q;
        for (int c = 0; c < CHANNELS; c++) begin
            att[c] = atten[3*c +: 3];
            v[c] = (att[c] == 3'd7 ? '0 : {1'b0, act_q[c] >> att[c]}) + (speaker ? HALF : '0);
            sum[c] = {1'b0, acc_q[c]} + {1'b0, v[c]};
            acc_d[c] = sum[c][WIDTH:0];
            aud_d[c] = sum[c][WIDTH+1];
            und_d[c] = tick_i & ~pf_q[c];
            act_d[c] = (tick_i && pf_q[c]) ? pend_q[c] : act_q[c];
            pend_d[c] = wr[c] ? s_data : pend_q[c];
            pf_d[c] = wr[c] | (pf_q[c] & ~tick_i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            tick_q <= 1'b0;
            pf_q <= '0;
            und_q <= '0;
            aud_q <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                pend_q[c] <= '0;
                act_q[c] <= MID;
                acc_q[c] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
            tick_q <= tick_i;
            pf_q <= pf_d;
            und_q <= und_d;
            aud_q <= aud_d;
            pend_q <= pend_d;
            act_q <= act_d;
            acc_q <= acc_d;
        end
    end

    assign s_ready = ~|(sel & pf_q);
    assign tick = tick_q;
    assign underrun = und_q;
    assign audio_out = aud_q;
endmodule

// File: tb/tb_sound_dac_sd.sv
// tb_sound_dac_sd: scoreboard bench with a behavioural reference model and density windows
module tb_sound_dac_sd;
    localparam int W = 8;
    localparam int NCH = 3;
    localparam int RD = 4;
    localparam int CW = 2;
    localparam int FULL = 512;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic s_valid = 1'b0;
    logic s_ready;
    logic [CW-1:0] s_chan = '0;
    logic [W-1:0] s_data = '0;
    logic [3*NCH-1:0] atten = '0;
    logic speaker = 1'b0;
    logic tick;
    logic [NCH-1:0] underrun, audio_out;

    always #5 clk = ~clk;

    sound_dac_sd #(.WIDTH(W), .CHANNELS(NCH), .RATE_DIV(RD)) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_chan(s_chan),
        .s_data(s_data), .atten(atten), .speaker(speaker), .tick(tick),
        .underrun(underrun), .audio_out(audio_out)
    );

    typedef struct {
        bit rdy;
        bit tk;
        bit [NCH-1:0] und;
        bit [NCH-1:0] aud;
        bit ws;
        bit we;
        bit [NCH-1:0][9:0] wexp;
    } exp_t;

    exp_t sbq[$];
    int errors = 0;
    int checks = 0;

    int m_cnt;
    bit m_pf[NCH];
    int m_pend[NCH], m_act[NCH], m_acc[NCH];
    bit m_tk;
    bit [NCH-1:0] m_und, m_aud;
    int smp[NCH];

    function automatic int vexp(int sample, int a, bit spk);
        return (a == 7 ? 0 : (sample >> a)) + (spk ? FULL / 4 : 0);
    endfunction

    function automatic bit m_ready(int ch);
        return ch >= NCH ? 1'b1 : !m_pf[ch];
    endfunction

    task automatic m_reset();
        m_cnt = 0;
        m_tk = 0;
        m_und = '0;
        m_aud = '0;
        for (int c = 0; c < NCH; c++) begin
            m_pf[c] = 0;
            m_pend[c] = 0;
            m_act[c] = 128;
            m_acc[c] = 0;
        end
    endtask

    task automatic cyc(bit ws = 0, bit we = 0);
        exp_t e;
        int a, v, s;
        bit bnd, acc_ok;
        if (!rst_n) m_reset();
        e.rdy = m_ready(int'(s_chan));
        e.tk = m_tk;
        e.und = m_und;
        e.aud = m_aud;
        e.ws = ws;
        e.we = we;
        for (int c = 0; c < NCH; c++) e.wexp[c] = 10'(vexp(smp[c], int'(atten[3*c +: 3]), speaker));
        sbq.push_back(e);
        if (rst_n) begin
            bnd = m_cnt == RD - 1;
            acc_ok = s_valid && m_ready(int'(s_chan));
            for (int c = 0; c < NCH; c++) begin
                a = int'(atten[3*c +: 3]);
                v = (a == 7 ? 0 : (m_act[c] >> a)) + (speaker ? 128 : 0);
                s = m_acc[c] + v;
                m_aud[c] = s >= FULL;
                m_acc[c] = s % FULL;
                m_und[c] = bnd && !m_pf[c];
                if (bnd && m_pf[c]) begin
                    m_act[c] = m_pend[c];
                    m_pf[c] = 0;
                end
            end
            if (acc_ok && int'(s_chan) < NCH) begin
                m_pend[s_chan] = int'(s_data);
                m_pf[s_chan] = 1;
            end
            m_tk = bnd;
            m_cnt = (m_cnt + 1) % RD;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic window();
        for (int i = 0; i < FULL; i++) cyc(i == 0, i == FULL - 1);
    endtask

    task automatic put(int ch, int d);
        bit ok;
        s_chan = CW'(ch);
        s_data = W'(d);
        s_valid = 1'b1;
        for (int i = 0; i < 3 * RD; i++) begin
            ok = m_ready(ch);
            cyc();
            if (ok) break;
        end
        s_valid = 1'b0;
    endtask

    task automatic do_reset(int n);
        rst_n = 1'b0;
        s_valid = 1'b0;
        run(n);
        rst_n = 1'b1;
        for (int c = 0; c < NCH; c++) smp[c] = 128;
    endtask

    task automatic chk(string nm, int act, int ex);
        checks++;
        if (act != ex) begin
            errors++;
            $display("FAIL %s t=%0t got=%0d exp=%0d", nm, $time, act, ex);
        end
    endtask

    initial begin
        exp_t e;
        int ones[NCH];
        for (int c = 0; c < NCH; c++) ones[c] = 0;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("s_ready", int'(s_ready), int'(e.rdy));
                chk("tick", int'(tick), int'(e.tk));
                chk("underrun", int'(underrun), int'(e.und));
                chk("audio_out", int'(audio_out), int'(e.aud));
                for (int c = 0; c < NCH; c++) ones[c] = (e.ws ? 0 : ones[c]) + int'(audio_out[c]);
                if (e.we)
                    for (int c = 0; c < NCH; c++) chk($sformatf("density_ch%0d", c), ones[c], int'(e.wexp[c]));
            end
        end
    end

    initial begin
        for (int c = 0; c < NCH; c++) smp[c] = 128;
        m_reset();
        @(posedge clk);
        #1;
        do_reset(3);
        run(2);
        window();
        do_reset(2);
        put(0, 255);
        put(1, 0);
        smp[0] = 255;
        smp[1] = 0;
        run(10);
        window();
        for (int i = 0; i < RD && m_cnt != 0; i++) cyc();
        put(0, 77);
        s_chan = 1;
        cyc();
        put(0, 99);
        smp[0] = 99;
        run(10);
        put(0, 200);
        smp[0] = 200;
        atten[2:0] = 3'd2;
        speaker = 1'b1;
        run(10);
        window();
        atten[2:0] = 3'd7;
        speaker = 1'b0;
        run(2);
        window();
        atten = '0;
        for (int i = 0; i < 4 * RD; i++) begin
            if (m_cnt == RD - 1 && !m_pf[0]) break;
            cyc();
        end
        s_valid = 1'b1;
        s_chan = 0;
        s_data = 8'd33;
        cyc();
        s_valid = 1'b0;
        run(2 * RD);
        s_chan = 2'd3;
        s_valid = 1'b1;
        for (int i = 0; i < 2 * RD; i++) begin
            s_data = W'($urandom);
            cyc();
        end
        s_valid = 1'b0;
        run(2 * RD);
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 499) != 0);
            s_valid = 1'($urandom_range(0, 1));
            s_chan = CW'($urandom_range(0, 3));
            s_data = W'($urandom);
            if ($urandom_range(0, 15) == 0) atten = (3*NCH)'($urandom);
            speaker = 1'($urandom_range(0, 1));
            cyc();
        end
        rst_n = 1'b1;
        s_valid = 1'b0;
        run(4);
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
